// File: rtl/bram_stream_reader.sv
// Streams DEPTH words from BRAM port B to a UART, one byte per tx_start.
// Re-arms only after master_state leaves the trigger value.
module bram_stream_reader #(
   parameter int M_STATE   = 1,
   parameter int MS_W      = 2,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int WORD_W    = 8,
   parameter int BRAM_LAT  = 2,
   parameter int TX_GUARD  = 3,
   parameter int LSB_FIRST = 1,
   parameter int ABORT_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MS_W-1:0]   master_state,
   input  logic [WORD_W-1:0] doutb,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   input  logic              tx_ongoing,
   output logic              tx_start,
   output logic [7:0]        byte_to_send,
   output logic              read_done,
   output logic [3:0]        status
);

   localparam int BYTES = WORD_W / 8;
   localparam logic [MS_W-1:0]   TRIG      = MS_W'(M_STATE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        LAST_LANE = 2'(BYTES - 1);
   localparam logic [3:0]        LAT_LAST  = 4'(BRAM_LAT - 2);
   localparam logic [3:0]        GRD_LAST  = 4'(TX_GUARD - 1);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_WAIT_TX = 4'd1,
      S_READ    = 4'd2,
      S_LAT     = 4'd3,
      S_LOAD    = 4'd4,
      S_SEND    = 4'd5,
      S_GUARD   = 4'd6,
      S_DONE    = 4'd7,
      S_REARM   = 4'd8
   } state_t;

   state_t            state_q, state_d;
   logic [MS_W-1:0]   ms_q;
   logic              txo_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        lane_q, lane_d;
   logic [1:0]        phys;
   logic [3:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] word_sh;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        byte_q, byte_d;
   logic              armed;
   logic              abort;
   logic              busy_state;

   assign armed   = (ms_q == TRIG);
   assign abort   = (ABORT_EN != 0) && !armed;
   assign phys    = (LSB_FIRST != 0) ? lane_q : LAST_LANE - lane_q;
   assign word_sh = word_q >> {phys, 3'b000};

   // States in which a transfer is in flight and may be aborted
   assign busy_state = (state_q == S_WAIT_TX) || (state_q == S_READ) ||
                       (state_q == S_LAT)     || (state_q == S_LOAD) ||
                       (state_q == S_SEND)    || (state_q == S_GUARD);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      tx_start_d = 1'b0;
      byte_d     = byte_q;
      unique case (state_q)
         S_IDLE: begin
            addr_d = '0;
            lane_d = '0;
            if (armed) state_d = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (!txo_q) state_d = (lane_q == 2'd0) ? S_READ : S_SEND;
         end
         S_READ: begin
            cnt_d   = '0;
            state_d = (BRAM_LAT == 1) ? S_LOAD : S_LAT;
         end
         S_LAT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_LAST) state_d = S_LOAD;
         end
         S_LOAD: begin
            word_d  = doutb;
            state_d = S_SEND;
         end
         S_SEND: begin
            tx_start_d = 1'b1;
            byte_d     = word_sh[7:0];
            cnt_d      = '0;
            state_d    = S_GUARD;
         end
         S_GUARD: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == GRD_LAST) begin
               if (lane_q < LAST_LANE) begin
                  lane_d  = lane_q + 2'd1;
                  state_d = S_WAIT_TX;
               end else if (addr_q < LAST_ADDR) begin
                  addr_d  = addr_q + 1'b1;
                  lane_d  = '0;
                  state_d = S_WAIT_TX;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_REARM;
         S_REARM: if (!armed) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && busy_state) begin
         state_d    = S_IDLE;
         addr_d     = '0;
         lane_d     = '0;
         tx_start_d = 1'b0;
         byte_d     = byte_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ms_q       <= '0;
         txo_q      <= 1'b0;
         addr_q     <= '0;
         lane_q     <= '0;
         cnt_q      <= '0;
         word_q     <= '0;
         tx_start_q <= 1'b0;
         byte_q     <= '0;
      end else begin
         state_q    <= state_d;
         ms_q       <= master_state;
         txo_q      <= tx_ongoing;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         tx_start_q <= tx_start_d;
         byte_q     <= byte_d;
      end
   end

   assign enb          = (state_q == S_READ) || (state_q == S_LAT);
   assign read_done    = (state_q == S_DONE);
   assign addrb        = addr_q;
   assign tx_start     = tx_start_q;
   assign byte_to_send = byte_q;
   assign status       = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: six parameter sets driven side by side,
// each with its own latency-matched BRAM model and busy-counter UART model.
module tb_bram_stream_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ms     [6];
   logic [31:0] dout  [6];
   logic       enb    [6];
   logic [9:0] addrb  [6];
   logic       txo    [6];
   logic       txs    [6];
   logic [7:0] bts    [6];
   logic       rdone  [6];
   logic [3:0] st     [6];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int depth_of(int g);
      case (g)
         0:       return 1024;
         1, 2:    return 4;
         3, 4:    return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int bytes_of(int g);
      return (g == 1 || g == 2) ? 4 : 1;
   endfunction

   function automatic int lat_of(int g);
      return (g == 3) ? 1 : (g == 4) ? 4 : 2;
   endfunction

   function automatic logic [31:0] data_of(int g, int a);
      if (bytes_of(g) == 4) return 32'hA0B0C0D0 + 32'(a);
      return 32'(a & 255);
   endfunction

   function automatic logic [7:0] exp_byte(int g, int n);
      int w, l, p;
      logic [31:0] d;
      w = (n / bytes_of(g)) % depth_of(g);
      l = n % bytes_of(g);
      p = (g == 2) ? bytes_of(g) - 1 - l : l;
      d = data_of(g, w);
      return 8'(d >> (8 * p));
   endfunction

   task automatic chk(string tag, int got, int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   bram_stream_reader u0 (
      .clk(clk), .rst(rst), .master_state(ms[0]), .doutb(dout[0][7:0]),
      .enb(enb[0]), .addrb(addrb[0]), .tx_ongoing(txo[0]), .tx_start(txs[0]),
      .byte_to_send(bts[0]), .read_done(rdone[0]), .status(st[0]));

   bram_stream_reader #(.WORD_W(32), .DEPTH(4), .LSB_FIRST(1)) u1 (
      .clk(clk), .rst(rst), .master_state(ms[1]), .doutb(dout[1]),
      .enb(enb[1]), .addrb(addrb[1]), .tx_ongoing(txo[1]), .tx_start(txs[1]),
      .byte_to_send(bts[1]), .read_done(rdone[1]), .status(st[1]));

   bram_stream_reader #(.WORD_W(32), .DEPTH(4), .LSB_FIRST(0)) u2 (
      .clk(clk), .rst(rst), .master_state(ms[2]), .doutb(dout[2]),
      .enb(enb[2]), .addrb(addrb[2]), .tx_ongoing(txo[2]), .tx_start(txs[2]),
      .byte_to_send(bts[2]), .read_done(rdone[2]), .status(st[2]));

   bram_stream_reader #(.DEPTH(8), .BRAM_LAT(1)) u3 (
      .clk(clk), .rst(rst), .master_state(ms[3]), .doutb(dout[3][7:0]),
      .enb(enb[3]), .addrb(addrb[3]), .tx_ongoing(txo[3]), .tx_start(txs[3]),
      .byte_to_send(bts[3]), .read_done(rdone[3]), .status(st[3]));

   bram_stream_reader #(.DEPTH(8), .BRAM_LAT(4)) u4 (
      .clk(clk), .rst(rst), .master_state(ms[4]), .doutb(dout[4][7:0]),
      .enb(enb[4]), .addrb(addrb[4]), .tx_ongoing(txo[4]), .tx_start(txs[4]),
      .byte_to_send(bts[4]), .read_done(rdone[4]), .status(st[4]));

   bram_stream_reader #(.DEPTH(32), .ABORT_EN(0)) u5 (
      .clk(clk), .rst(rst), .master_state(ms[5]), .doutb(dout[5][7:0]),
      .enb(enb[5]), .addrb(addrb[5]), .tx_ongoing(txo[5]), .tx_start(txs[5]),
      .byte_to_send(bts[5]), .read_done(rdone[5]), .status(st[5]));

   for (genvar g = 0; g < 6; g++) begin : g_m
      logic [31:0] pipe [4];
      int bcnt = 0;
      int busy_len = 0;
      int n_tx = 0;
      int n_done = 0;
      int err = 0;
      int base = 0;
      int tx_cyc [8];
      logic [7:0] tx_byte [8];

      // Data only appears if enb was high when the address was presented
      assign dout[g] = pipe[lat_of(g) - 1];
      assign txo[g]  = (bcnt != 0);

      always @(posedge clk) begin
         pipe[0] <= enb[g] ? data_of(g, int'(addrb[g])) : 32'hDEADBEEF;
         for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
         if (txs[g]) bcnt <= busy_len;
         else if (bcnt > 0) bcnt <= bcnt - 1;
      end

      always @(negedge clk) begin
         if (txs[g]) begin
            if (n_tx >= base && n_tx - base < 8) begin
               tx_cyc[n_tx-base]  <= cyc;
               tx_byte[n_tx-base] <= bts[g];
            end
            if (bts[g] != exp_byte(g, n_tx - base)) err <= err + 1;
            n_tx <= n_tx + 1;
         end
         if (rdone[g]) n_done <= n_done + 1;
      end
   end

   initial begin
      int trig;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) ms[i] = 2'd0;
      g_m[0].busy_len = 20;
      tick(3);

      chk("rst enb", int'(enb[0]), 0);
      chk("rst addrb", int'(addrb[0]), 0);
      chk("rst tx_start", int'(txs[0]), 0);
      chk("rst byte", int'(bts[0]), 0);
      chk("rst read_done", int'(rdone[0]), 0);
      chk("rst status", int'(st[0]), 0);

      rst = 1'b0;
      tick(2);

      // Trigger every instance on the same edge
      for (int i = 0; i < 6; i++) ms[i] = 2'd1;
      trig = cyc + 1;
      for (int i = 0; i < 60 && (g_m[4].n_tx < 5 || g_m[1].n_tx < 5); i++)
         tick(1);

      // tx_start is seen in the cycle ending at edge trig+5+LAT
      chk("first tx lat2", g_m[0].tx_cyc[0] - trig, 6);
      chk("first tx lat1", g_m[3].tx_cyc[0] - trig, 5);
      chk("first tx lat4", g_m[4].tx_cyc[0] - trig, 8);
      chk("lane1 period", g_m[1].tx_cyc[1] - g_m[1].tx_cyc[0], 5);
      chk("lane0 period", g_m[1].tx_cyc[4] - g_m[1].tx_cyc[3], 8);

      chk("lsb b0", int'(g_m[1].tx_byte[0]), 'hD0);
      chk("lsb b1", int'(g_m[1].tx_byte[1]), 'hC0);
      chk("lsb b3", int'(g_m[1].tx_byte[3]), 'hA0);
      chk("lsb b4", int'(g_m[1].tx_byte[4]), 'hD1);
      chk("msb b0", int'(g_m[2].tx_byte[0]), 'hA0);
      chk("msb b3", int'(g_m[2].tx_byte[3]), 'hD0);
      chk("msb b4", int'(g_m[2].tx_byte[4]), 'hA0);

      for (int i = 0; i < 500 && g_m[5].n_tx < 10; i++) tick(1);
      ms[5] = 2'd2;

      for (int i = 0; i < 40000 && g_m[0].n_done == 0; i++) tick(1);
      tick(5);
      chk("u0 bytes", g_m[0].n_tx, 1024);
      chk("u0 done", g_m[0].n_done, 1);
      chk("u0 rearm", int'(st[0]), 8);
      chk("u1 bytes held", g_m[1].n_tx, 16);
      chk("u1 done held", g_m[1].n_done, 1);
      chk("u1 rearm", int'(st[1]), 8);
      chk("u2 bytes", g_m[2].n_tx, 16);
      chk("u3 bytes", g_m[3].n_tx, 8);
      chk("u4 bytes", g_m[4].n_tx, 8);
      chk("noabort bytes", g_m[5].n_tx, 32);
      chk("noabort done", g_m[5].n_done, 1);

      ms[0] = 2'd0;
      tick(3);
      chk("u0 idle", int'(st[0]), 0);
      chk("u0 idle addr", int'(addrb[0]), 0);

      ms[1] = 2'd0;
      tick(3);
      ms[1] = 2'd1;
      tick(200);
      chk("u1 second bytes", g_m[1].n_tx, 32);
      chk("u1 second done", g_m[1].n_done, 2);

      // Abort after the 10th byte
      g_m[0].busy_len = 4;
      g_m[0].base = g_m[0].n_tx;
      ms[0] = 2'd1;
      for (int i = 0; i < 2000 && g_m[0].n_tx - g_m[0].base < 10; i++) tick(1);
      ms[0] = 2'd2;
      tick(100);
      chk("abort bytes", g_m[0].n_tx - g_m[0].base, 10);
      chk("abort no done", g_m[0].n_done, 1);
      chk("abort status", int'(st[0]), 0);
      chk("abort addrb", int'(addrb[0]), 0);

      // Reset while byte 500 is in its guard window
      g_m[0].base = g_m[0].n_tx;
      ms[0] = 2'd1;
      for (int i = 0; i < 20000 && g_m[0].n_tx - g_m[0].base < 501; i++) tick(1);
      chk("guard state", int'(st[0]), 6);
      chk("guard addrb", int'(addrb[0]), 500);
      rst = 1'b1;
      tick(1);
      chk("mid rst enb", int'(enb[0]), 0);
      chk("mid rst addrb", int'(addrb[0]), 0);
      chk("mid rst tx_start", int'(txs[0]), 0);
      chk("mid rst byte", int'(bts[0]), 0);
      chk("mid rst read_done", int'(rdone[0]), 0);
      chk("mid rst status", int'(st[0]), 0);
      rst = 1'b0;
      g_m[0].base = g_m[0].n_tx;
      for (int i = 0; i < 100 && g_m[0].n_tx == g_m[0].base; i++) tick(1);
      chk("restart count", g_m[0].n_tx - g_m[0].base, 1);
      chk("restart byte", int'(g_m[0].tx_byte[0]), 0);
      chk("restart addrb", int'(addrb[0]), 0);
      chk("rst no done", g_m[0].n_done, 1);

      for (int i = 0; i < 6; i++) begin
         case (i)
            0: chk("u0 stream", g_m[0].err, 0);
            1: chk("u1 stream", g_m[1].err, 0);
            2: chk("u2 stream", g_m[2].err, 0);
            3: chk("u3 stream", g_m[3].err, 0);
            4: chk("u4 stream", g_m[4].err, 0);
            default: chk("u5 stream", g_m[5].err, 0);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
